// File: rtl/ebi_pkg.sv
// EBI bridge shared definitions: address map helpers,
// STATUS bit positions and the commit FSM encoding.
package ebi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    HOLD
  } state_t;

  localparam int ST_CMD_AF    = 15;
  localparam int ST_CMD_FULL  = 14;
  localparam int ST_CMD_AE    = 13;
  localparam int ST_CMD_EMPTY = 12;
  localparam int ST_SMP_AF    = 11;
  localparam int ST_SMP_FULL  = 10;
  localparam int ST_SMP_EMPTY = 9;
  localparam int ST_SMP_AE    = 8;
  localparam int ST_CMD_OVF   = 7;
  localparam int ST_SMP_UDF   = 6;

  localparam int IRQ_BASE = 6;
  localparam int IRQ_W    = 10;

  function automatic int addr_sample(input int cw);
    return cw + 1;
  endfunction

  function automatic int addr_mask(input int cw);
    return cw + 2;
  endfunction

  function automatic int addr_drop(input int cw);
    return cw + 3;
  endfunction

endpackage

// File: rtl/ebi_cmd_assembler.sv
// Holds the per-word command captures and packs them
// word 1 first (MSBs) into the command FIFO word.
module ebi_cmd_assembler #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 19,
  parameter int CMD_WORDS = 4,
  localparam int CMD_W    = DATA_W * CMD_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [CMD_W-1:0]  cmd,
  output logic              commit
);

  logic [DATA_W-1:0] cap [CMD_WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CMD_WORDS; k++)
        cap[k] <= '0;
    end else if (we) begin
      for (int k = 0; k < CMD_WORDS; k++)
        if (addr == ADDR_W'(k + 1))
          cap[k] <= data_in;
    end
  end

  always_comb begin
    cmd = '0;
    for (int k = 0; k < CMD_WORDS; k++)
      cmd[CMD_W-1-k*DATA_W -: DATA_W] = cap[k];
  end

  assign commit = we && (addr == ADDR_W'(CMD_WORDS));

endmodule

// File: rtl/ebi_bridge.sv
// EBI-to-FIFO bridge: strobe edge detect, commit FSM,
// register read mux, sticky flags, drop counter and irq.
module ebi_bridge
  import ebi_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 19,
  parameter int CMD_WORDS = 4,
  localparam int CMD_W    = DATA_W * CMD_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic              cs,
  output logic [CMD_W-1:0]  cmd_fifo_data_in,
  output logic              cmd_fifo_wr_en,
  input  logic              cmd_fifo_almost_full,
  input  logic              cmd_fifo_full,
  input  logic              cmd_fifo_almost_empty,
  input  logic              cmd_fifo_empty,
  input  logic [DATA_W-1:0] sample_fifo_data_out,
  output logic              sample_fifo_rd_en,
  input  logic              sample_fifo_almost_full,
  input  logic              sample_fifo_full,
  input  logic              sample_fifo_almost_empty,
  input  logic              sample_fifo_empty,
  output logic              irq
);

  state_t           state;
  logic             wr_q;
  logic             rd_q;
  logic             cmd_ovf;
  logic             smp_udf;
  logic [IRQ_W-1:0] irq_mask;
  logic [15:0]      drop_cnt;
  logic [15:0]      status;
  logic [DATA_W-1:0] rdata;

  logic wr_s, rd_s, we, re, commit;
  logic is_status, is_sample, is_mask, is_drop;
  logic ovf_set, udf_set, ovf_clr, udf_clr;

  assign wr_s = cs & wr;
  assign rd_s = cs & rd;
  // A simultaneous write strobe turns the access into a write.
  assign we = (state == IDLE) & wr_s & ~wr_q;
  assign re = (state == IDLE) & rd_s & ~rd_q & ~wr_s;

  assign is_status = addr == '0;
  assign is_sample = addr == ADDR_W'(addr_sample(CMD_WORDS));
  assign is_mask   = addr == ADDR_W'(addr_mask(CMD_WORDS));
  assign is_drop   = addr == ADDR_W'(addr_drop(CMD_WORDS));

  ebi_cmd_assembler #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .CMD_WORDS (CMD_WORDS)
  ) u_asm (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .addr    (addr),
    .data_in (data_in),
    .cmd     (cmd_fifo_data_in),
    .commit  (commit)
  );

  always_comb begin
    status = '0;
    status[ST_CMD_AF]    = cmd_fifo_almost_full;
    status[ST_CMD_FULL]  = cmd_fifo_full;
    status[ST_CMD_AE]    = cmd_fifo_almost_empty;
    status[ST_CMD_EMPTY] = cmd_fifo_empty;
    status[ST_SMP_AF]    = sample_fifo_almost_full;
    status[ST_SMP_FULL]  = sample_fifo_full;
    status[ST_SMP_EMPTY] = sample_fifo_empty;
    status[ST_SMP_AE]    = sample_fifo_almost_empty;
    status[ST_CMD_OVF]   = cmd_ovf;
    status[ST_SMP_UDF]   = smp_udf;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_status: rdata = DATA_W'(status);
      is_sample: if (!sample_fifo_empty)
                   rdata = sample_fifo_data_out;
      is_mask:   rdata = DATA_W'(irq_mask);
      is_drop:   rdata = DATA_W'(drop_cnt);
      default:   rdata = '0;
    endcase
  end

  assign ovf_set = (state == COMMIT) & cmd_fifo_full;
  assign udf_set = re & is_sample & sample_fifo_empty;
  assign ovf_clr = we & is_status & data_in[ST_CMD_OVF];
  assign udf_clr = we & is_status & data_in[ST_SMP_UDF];

  // Strobes are gated with rst so an aborted commit never pushes.
  assign cmd_fifo_wr_en    = (state == COMMIT) & ~cmd_fifo_full & ~rst;
  assign sample_fifo_rd_en = re & is_sample & ~sample_fifo_empty & ~rst;

  always_ff @(posedge clk) begin
    wr_q <= wr_s;
    rd_q <= rd_s;
    if (rst) begin
      state    <= IDLE;
      data_out <= '0;
      irq      <= 1'b0;
      cmd_ovf  <= 1'b0;
      smp_udf  <= 1'b0;
      irq_mask <= '0;
      drop_cnt <= '0;
    end else begin
      irq     <= |(status[IRQ_BASE +: IRQ_W] & irq_mask);
      cmd_ovf <= ovf_set | (cmd_ovf & ~ovf_clr);
      smp_udf <= udf_set | (smp_udf & ~udf_clr);
      if (re)
        data_out <= rdata;
      if (we & is_mask)
        irq_mask <= data_in[IRQ_W-1:0];
      if (ovf_set) begin
        if (drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end else if (we & is_drop) begin
        drop_cnt <= '0;
      end
      unique case (state)
        IDLE:    if (commit) state <= COMMIT;
        COMMIT:  state <= HOLD;
        HOLD:    if (!(cs & (wr | rd))) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ebi_bridge.sv
// Self-checking bench for ebi_bridge (DATA_W=16, CMD_WORDS=4)
// with a transaction-level reference model.
module tb_ebi_bridge;

  localparam int DW = 16;
  localparam int AW = 19;
  localparam int CW = 4;
  localparam int CMDW = DW * CW;

  logic clk = 0;
  logic rst = 0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic [AW-1:0] addr = '0;
  logic rd = 0, wr = 0, cs = 0;
  logic [CMDW-1:0] cmd_fifo_data_in;
  logic cmd_fifo_wr_en;
  logic cmd_fifo_almost_full = 0, cmd_fifo_full = 0;
  logic cmd_fifo_almost_empty = 0, cmd_fifo_empty = 1;
  logic [DW-1:0] sample_fifo_data_out = '0;
  logic sample_fifo_rd_en;
  logic sample_fifo_almost_full = 0, sample_fifo_full = 0;
  logic sample_fifo_almost_empty = 0, sample_fifo_empty = 1;
  logic irq;

  ebi_bridge #(.DATA_W(DW), .ADDR_W(AW), .CMD_WORDS(CW)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .data_in                  (data_in),
    .data_out                 (data_out),
    .addr                     (addr),
    .rd                       (rd),
    .wr                       (wr),
    .cs                       (cs),
    .cmd_fifo_data_in         (cmd_fifo_data_in),
    .cmd_fifo_wr_en           (cmd_fifo_wr_en),
    .cmd_fifo_almost_full     (cmd_fifo_almost_full),
    .cmd_fifo_full            (cmd_fifo_full),
    .cmd_fifo_almost_empty    (cmd_fifo_almost_empty),
    .cmd_fifo_empty           (cmd_fifo_empty),
    .sample_fifo_data_out     (sample_fifo_data_out),
    .sample_fifo_rd_en        (sample_fifo_rd_en),
    .sample_fifo_almost_full  (sample_fifo_almost_full),
    .sample_fifo_full         (sample_fifo_full),
    .sample_fifo_almost_empty (sample_fifo_almost_empty),
    .sample_fifo_empty        (sample_fifo_empty),
    .irq                      (irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int push_cnt = 0;
  int pop_cnt = 0;
  logic [CMDW-1:0] push_data = '0;

  always @(negedge clk) begin
    if (cmd_fifo_wr_en) begin
      push_cnt++;
      push_data = cmd_fifo_data_in;
    end
    if (sample_fifo_rd_en) pop_cnt++;
  end

  logic [15:0] m_cap [1:4];
  bit          m_ovf, m_udf;
  logic [9:0]  m_mask;
  int          m_drop;
  logic [15:0] m_dout;

  task automatic model_reset();
    for (int k = 1; k <= 4; k++) m_cap[k] = '0;
    m_ovf = 0; m_udf = 0; m_mask = '0; m_drop = 0; m_dout = '0;
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = '0;
    s[15] = cmd_fifo_almost_full;
    s[14] = cmd_fifo_full;
    s[13] = cmd_fifo_almost_empty;
    s[12] = cmd_fifo_empty;
    s[11] = sample_fifo_almost_full;
    s[10] = sample_fifo_full;
    s[9]  = sample_fifo_empty;
    s[8]  = sample_fifo_almost_empty;
    s[7]  = m_ovf;
    s[6]  = m_udf;
    return s;
  endfunction

  function automatic bit m_irq();
    logic [15:0] s;
    s = m_status();
    return |(s[15:6] & m_mask);
  endfunction

  // One bus access: update the model, drive the strobe, check effects.
  task automatic xact(input bit w, input bit r, input int a,
                      input logic [15:0] d, input int hold,
                      input string nm);
    int exp_push, exp_pop, p0, q0;
    logic [CMDW-1:0] exp_data;
    logic [15:0] st;
    exp_push = 0; exp_pop = 0; exp_data = '0;
    st = m_status();
    if (w) begin
      if (a >= 1 && a <= 4) m_cap[a] = d;
      if (a == 4) begin
        if (cmd_fifo_full) begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end else begin
          exp_push = 1;
          exp_data = {m_cap[1], m_cap[2], m_cap[3], m_cap[4]};
        end
      end else if (a == 0) begin
        if (d[7]) m_ovf = 0;
        if (d[6]) m_udf = 0;
      end else if (a == 6) begin
        m_mask = d[9:0];
      end else if (a == 7) begin
        m_drop = 0;
      end
    end else if (r) begin
      case (a)
        0: m_dout = st;
        5: begin
          if (sample_fifo_empty) begin
            m_dout = '0;
            m_udf = 1;
          end else begin
            m_dout = sample_fifo_data_out;
            exp_pop = 1;
          end
        end
        6: m_dout = {6'b0, m_mask};
        7: m_dout = m_drop[15:0];
        default: m_dout = '0;
      endcase
    end
    p0 = push_cnt; q0 = pop_cnt;
    @(posedge clk); #1;
    addr = AW'(a); data_in = d; cs = 1; wr = w; rd = r;
    repeat (hold) @(posedge clk);
    #1; cs = 0; wr = 0; rd = 0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (push_cnt - p0 !== exp_push) begin
      fails++;
      $display("FAIL %s push count got %0d want %0d", nm,
               push_cnt - p0, exp_push);
    end
    if (exp_push == 1) begin
      tests++;
      if (push_data !== exp_data) begin
        fails++;
        $display("FAIL %s push data got %h want %h", nm,
                 push_data, exp_data);
      end
    end
    tests++;
    if (pop_cnt - q0 !== exp_pop) begin
      fails++;
      $display("FAIL %s pop count got %0d want %0d", nm,
               pop_cnt - q0, exp_pop);
    end
    tests++;
    if (data_out !== m_dout) begin
      fails++;
      $display("FAIL %s data_out got %h want %h", nm, data_out, m_dout);
    end
    tests++;
    if (irq !== m_irq()) begin
      fails++;
      $display("FAIL %s irq got %b want %b", nm, irq, m_irq());
    end
  endtask

  task automatic test_reset();
    rst = 1;
    cs = 1; wr = 1; rd = 0; addr = AW'(4);
    repeat (3) @(posedge clk);
    #1; cs = 0; wr = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    @(negedge clk);
    tests++;
    if (data_out !== '0) begin
      fails++;
      $display("FAIL reset data_out got %h want 0", data_out);
    end
    tests++;
    if (cmd_fifo_wr_en !== 1'b0 || sample_fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL reset strobes got %b%b want 00",
               cmd_fifo_wr_en, sample_fifo_rd_en);
    end
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL reset irq got %b want 0", irq);
    end
    tests++;
    if (cmd_fifo_data_in !== '0) begin
      fails++;
      $display("FAIL reset captures got %h want 0", cmd_fifo_data_in);
    end
  endtask

  task automatic test_cmd_assemble();
    cmd_fifo_full = 0;
    xact(1, 0, 1, 16'h1111, 1, "cmd_w1");
    xact(1, 0, 2, 16'h2222, 2, "cmd_w2");
    xact(1, 0, 3, 16'h3333, 1, "cmd_w3");
    xact(1, 0, 4, 16'h4444, 5, "cmd_w4_hold");
    xact(1, 0, 2, 16'hBEEF, 1, "cmd_reorder_w2");
    xact(1, 0, 4, 16'h0004, 1, "cmd_recommit");
  endtask

  task automatic test_overflow();
    cmd_fifo_full = 1;
    xact(1, 0, 4, 16'hAAAA, 1, "ovf_w4_a");
    xact(1, 0, 4, 16'h5555, 1, "ovf_w4_b");
    xact(0, 1, 0, 16'h0, 1, "ovf_status");
    tests++;
    if (data_out[7] !== 1'b1) begin
      fails++;
      $display("FAIL ovf_bit7 got %b want 1", data_out[7]);
    end
    xact(0, 1, 7, 16'h0, 1, "ovf_drop_cnt");
    tests++;
    if (data_out !== 16'd2) begin
      fails++;
      $display("FAIL ovf_drop2 got %h want 0002", data_out);
    end
    xact(1, 0, 0, 16'h0080, 1, "ovf_w1c");
    xact(0, 1, 0, 16'h0, 1, "ovf_status_clr");
    xact(1, 0, 7, 16'h1234, 1, "drop_clear");
    xact(0, 1, 7, 16'h0, 1, "drop_read0");
    cmd_fifo_full = 0;
  endtask

  task automatic test_sample();
    sample_fifo_empty = 0;
    sample_fifo_data_out = 16'hA5A5;
    xact(0, 1, 5, 16'h0, 1, "smp_pop");
    xact(0, 1, 5, 16'h0, 4, "smp_pop_hold");
    sample_fifo_empty = 1;
    xact(0, 1, 5, 16'h0, 1, "smp_empty");
    xact(0, 1, 0, 16'h0, 1, "smp_status_udf");
    tests++;
    if (data_out[6] !== 1'b1) begin
      fails++;
      $display("FAIL smp_udf_bit got %b want 1", data_out[6]);
    end
    xact(1, 0, 0, 16'h0040, 1, "smp_w1c");
  endtask

  task automatic test_irq();
    sample_fifo_empty = 0;
    xact(1, 0, 6, 16'h0008, 1, "irq_mask_set");
    @(posedge clk); #1;
    sample_fifo_empty = 1;
    @(negedge clk);
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_latency_early got %b want 0", irq);
    end
    @(negedge clk);
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL irq_latency_one got %b want 1", irq);
    end
    xact(0, 1, 6, 16'h0, 1, "irq_mask_read");
    xact(1, 0, 6, 16'h0000, 1, "irq_mask_clr");
  endtask

  task automatic test_reset_commit();
    int p0;
    cmd_fifo_full = 0;
    xact(1, 0, 6, 16'h03FF, 1, "rc_mask");
    xact(1, 0, 1, 16'hCAFE, 1, "rc_w1");
    p0 = push_cnt;
    @(posedge clk); #1;
    addr = AW'(4); data_in = 16'h7777; cs = 1; wr = 1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    cs = 0; wr = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (push_cnt - p0 !== 0) begin
      fails++;
      $display("FAIL rc_no_push got %0d want 0", push_cnt - p0);
    end
    tests++;
    if (data_out !== '0 || irq !== 1'b0) begin
      fails++;
      $display("FAIL rc_outputs got dout=%h irq=%b want 0 0",
               data_out, irq);
    end
    xact(0, 1, 6, 16'h0, 1, "rc_mask_read");
    xact(0, 1, 7, 16'h0, 1, "rc_drop_read");
    xact(0, 1, 0, 16'h0, 1, "rc_status_read");
    xact(1, 0, 4, 16'h0044, 1, "rc_caps_cleared");
  endtask

  task automatic test_both_strobes();
    sample_fifo_empty = 0;
    sample_fifo_data_out = 16'h1357;
    xact(0, 1, 7, 16'h0, 1, "both_pre");
    xact(1, 1, 5, 16'hFFFF, 2, "both_addr5");
    xact(1, 1, 2, 16'h9999, 1, "both_addr2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      int a, kind;
      cmd_fifo_full = ($urandom_range(0, 3) == 0);
      cmd_fifo_almost_full = $urandom_range(0, 1);
      cmd_fifo_almost_empty = $urandom_range(0, 1);
      cmd_fifo_empty = $urandom_range(0, 1);
      sample_fifo_empty = ($urandom_range(0, 2) == 0);
      sample_fifo_almost_empty = $urandom_range(0, 1);
      sample_fifo_almost_full = $urandom_range(0, 1);
      sample_fifo_full = $urandom_range(0, 1);
      sample_fifo_data_out = 16'($urandom);
      a = $urandom_range(0, 8);
      kind = $urandom_range(0, 4);
      xact(kind <= 1 || kind == 4, kind >= 2, a, 16'($urandom),
           $urandom_range(1, 3), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_cmd_assemble();
    test_overflow();
    test_sample();
    test_irq();
    test_reset_commit();
    test_both_strobes();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
